// File: rtl/instr_fetch.sv
// Fetch stage: PC register, single-outstanding imem handshake, instruction register and next-PC logic.
// Optional retired-instruction counter enabled by defining INSTR_COUNT_EN.
module instr_fetch #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              PC_INC   = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_valid,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [5:0]      opcode,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [15:0]     imm,
  output logic [PC_W-1:0] pc_out,
  input  logic            next_ready,
  input  logic            stall,
  input  logic [1:0]      branch,
  input  logic            br_taken,
  input  logic [PC_W-1:0] reg_target,
  input  logic            halt
`ifdef INSTR_COUNT_EN
  ,
  output logic [31:0]     retired_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, ISSUE, HALTED} state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_out_q, pc_out_d;
  logic [31:0]     ir_q, ir_d;
  logic [PC_W-1:0] seq_pc, br_off, next_pc;
  logic            advance;

  assign advance = (state_q == ISSUE) && next_ready && !stall;
  assign seq_pc  = pc_q + PC_W'(PC_INC);
  // Word offset: sign-extended imm scaled to bytes
  assign br_off  = {{(PC_W-18){ir_q[15]}}, ir_q[15:0], 2'b00};

  always_comb begin
    next_pc = seq_pc;
    case (branch)
      2'b00:   next_pc = seq_pc;
      2'b01:   next_pc = br_taken ? seq_pc + br_off : seq_pc;
      2'b10:   next_pc = seq_pc + br_off;
      default: next_pc = reg_target & ~PC_W'(3);
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pc_out_d  = pc_out_q;
    ir_d      = ir_q;
    imem_req  = 1'b0;
    imem_addr = '0;
    case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        imem_req  = 1'b1;
        imem_addr = pc_q;
        state_d   = WAIT;
      end
      WAIT: begin
        if (imem_valid) begin
          ir_d     = imem_rdata;
          pc_out_d = pc_q;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (advance) begin
          pc_d    = next_pc;
          state_d = halt ? HALTED : FETCH;
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      pc_out_q <= '0;
      ir_q     <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      ir_q     <= ir_d;
    end
  end

  assign instr_valid = (state_q == ISSUE);
  assign instr       = ir_q;
  assign opcode      = ir_q[31:26];
  assign rs          = ir_q[25:21];
  assign rt          = ir_q[20:16];
  assign imm         = ir_q[15:0];
  assign pc_out      = pc_out_q;

`ifdef INSTR_COUNT_EN
  logic [31:0] cnt_q, cnt_d;

  assign cnt_d = advance ? cnt_q + 32'd1 : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign retired_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: table of fetch/branch vectors plus stall, halt and mid-WAIT reset sequences.
// Expected fetch addresses flow through a scoreboard queue; define INSTR_COUNT_EN to cover retired_cnt.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        instr_valid;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt;
  logic [15:0] imm;
  logic [31:0] pc_out;
  logic        next_ready, stall, br_taken, halt;
  logic [1:0]  branch;
  logic [31:0] reg_target;
`ifdef INSTR_COUNT_EN
  logic [31:0] retired_cnt;
`endif

  instr_fetch #(.PC_W(32), .RESET_PC(32'h0), .PC_INC(4)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .instr_valid(instr_valid), .instr(instr), .opcode(opcode),
    .rs(rs), .rt(rt), .imm(imm), .pc_out(pc_out),
    .next_ready(next_ready), .stall(stall), .branch(branch),
    .br_taken(br_taken), .reg_target(reg_target), .halt(halt)
`ifdef INSTR_COUNT_EN
    , .retired_cnt(retired_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic [1:0]  br;
    logic        taken;
    logic [31:0] rtgt;
    int          lat;
    int          stall_cyc;
    logic [31:0] exp_next;
  } vec_t;

  vec_t        vecs[12];
  logic [31:0] exp_addr_q[$];
  int          n_vec  = 0;
  int          n_fail = 0;
  int          n_adv  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (imem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_vec++;
      n_fail++;
      $display("FAIL req_timeout: got no imem_req expected imem_req within 50 cycles");
    end
  endtask

  task automatic check_cnt();
`ifdef INSTR_COUNT_EN
    chk("retired_cnt", retired_cnt, n_adv);
`endif
  endtask

  task automatic run_vec(input vec_t v, input bit do_halt);
    bit          ok;
    logic [31:0] cur;
    wait_req(ok);
    if (!ok) return;
    cur = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 32'hBAD0_BAD0;
    chk("imem_addr", imem_addr, cur);
    @(negedge clk);
    chk("req_one_cycle", imem_req, 1'b0);
    for (int i = 1; i < v.lat; i++) begin
      chk("valid_while_wait", instr_valid, 1'b0);
      @(negedge clk);
    end
    imem_rdata = v.word;
    imem_valid = 1'b1;
    @(negedge clk);
    imem_valid = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    chk("instr_valid", instr_valid, 1'b1);
    chk("instr", instr, v.word);
    chk("opcode", opcode, v.word[31:26]);
    chk("rs", rs, v.word[25:21]);
    chk("rt", rt, v.word[20:16]);
    chk("imm", imm, v.word[15:0]);
    chk("pc_out", pc_out, cur);
    for (int i = 0; i < v.stall_cyc; i++) begin
      stall = 1'b1;
      next_ready = 1'b1;
      if (i == 1) begin
        imem_valid = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
      end
      @(negedge clk);
      imem_valid = 1'b0;
      chk("stall_no_req", imem_req, 1'b0);
      chk("stall_instr", instr, v.word);
      chk("stall_pc_out", pc_out, cur);
      chk("stall_valid", instr_valid, 1'b1);
    end
    stall      = 1'b0;
    branch     = v.br;
    br_taken   = v.taken;
    reg_target = v.rtgt;
    halt       = do_halt;
    next_ready = 1'b1;
    @(negedge clk);
    next_ready = 1'b0;
    branch     = 2'b00;
    br_taken   = 1'b0;
    reg_target = 32'h0;
    halt       = 1'b0;
    n_adv++;
    chk("valid_drop", instr_valid, 1'b0);
    check_cnt();
    if (!do_halt) exp_addr_q.push_back(v.exp_next);
    $display("vec pc=%08h word=%08h branch=%0d taken=%0d next=%08h", cur, v.word, v.br, v.taken,
             v.exp_next);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    //           word          br     tk    rtgt          lat stl next
    vecs[0]  = '{32'h0400_0000, 2'b00, 1'b0, 32'h0,        1, 0, 32'h0000_0004};
    vecs[1]  = '{32'h0400_0000, 2'b00, 1'b1, 32'h0,        1, 0, 32'h0000_0008};
    vecs[2]  = '{32'h0400_0000, 2'b11, 1'b0, 32'h13,       3, 4, 32'h0000_0010};
    vecs[3]  = '{32'h1085_FFFE, 2'b01, 1'b1, 32'h0,        1, 0, 32'h0000_000C};
    vecs[4]  = '{32'h0800_0001, 2'b10, 1'b0, 32'h0,        1, 0, 32'h0000_0014};
    vecs[5]  = '{32'h0800_FFFE, 2'b10, 1'b1, 32'h0,        2, 0, 32'h0000_0010};
    vecs[6]  = '{32'h1085_FFFE, 2'b01, 1'b0, 32'h0,        1, 0, 32'h0000_0014};
    vecs[7]  = '{32'h0C00_0000, 2'b11, 1'b0, 32'h1237,     1, 0, 32'h0000_1234};
    vecs[8]  = '{32'h0C00_0000, 2'b11, 1'b1, 32'hFFFF_FFFF,1, 0, 32'hFFFF_FFFC};
    vecs[9]  = '{32'h0400_0000, 2'b00, 1'b0, 32'h0,        1, 0, 32'h0000_0000};
    vecs[10] = '{32'h0800_7FFF, 2'b10, 1'b0, 32'h0,        1, 0, 32'h0002_0000};
    vecs[11] = '{32'h1000_FFFF, 2'b01, 1'b1, 32'h0,        1, 0, 32'h0002_0000};

    rst = 1'b1; imem_rdata = 32'h0; imem_valid = 1'b0;
    next_ready = 1'b0; stall = 1'b0; branch = 2'b00; br_taken = 1'b0;
    reg_target = 32'h0; halt = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc_out", pc_out, 32'h0);
    check_cnt();
    rst = 1'b0;
    exp_addr_q.push_back(32'h0);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], 1'b0);

    // Halt on advance: no further requests, spurious responses ignored
    run_vec(vecs[0], 1'b1);
    for (int i = 0; i < 8; i++) begin
      imem_valid = (i == 2);
      imem_rdata = 32'h1234_5678;
      @(negedge clk);
      chk("halt_no_req", imem_req, 1'b0);
      chk("halt_no_valid", instr_valid, 1'b0);
    end
    imem_valid = 1'b0;
    check_cnt();

    // Reset mid-WAIT followed by a late memory response
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_adv = 0;
    check_cnt();
    wait_req(ok);
    chk("rfetch_addr", imem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    imem_valid = 1'b1;
    imem_rdata = 32'h1234_5678;
    @(negedge clk);
    imem_valid = 1'b0;
    chk("late_instr", instr, 32'h0);
    chk("late_valid", instr_valid, 1'b0);
    check_cnt();
    exp_addr_q.push_back(32'h0);
    run_vec(vecs[0], 1'b0);
    run_vec(vecs[1], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
